// File: rtl/regfile_scoreboard.sv
// Register bank with N combinational read ports, write-back bypass, an optional hardwired-zero
// register and a per-register busy scoreboard that tracks in-flight destinations for decode.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_issue_valid,
    input  logic [AW-1:0]       i_issue_rd,
    output logic                o_issue_ready,
    input  logic                i_wb_valid,
    input  logic [AW-1:0]       i_wb_addr,
    input  logic [XLEN-1:0]     i_wb_data,
    input  logic                i_flush,
    output logic [NREGS-1:0]    o_busy_vec,
    output logic [AW:0]         o_pending_cnt,
    output logic                o_err
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             err_q, err_d;

    logic wb_zero, iss_zero, wb_frees_iss, issue_ready, issue_accept, wr_en;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Per-port read: zero register masks everything, then bypass, then stored value.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          zr;
        logic          hit;

        assign ra  = i_rd_addr[k*AW +: AW];
        assign zr  = is_zero(ra);
        assign hit = (BYPASS != 0) && i_wb_valid && (i_wb_addr == ra);

        assign o_rd_data[k*XLEN +: XLEN] = zr ? '0 : (hit ? i_wb_data : regs_q[ra]);
        assign o_rd_busy[k]              = !zr && busy_q[ra] && !hit;
    end

    always_comb begin
        wb_zero      = is_zero(i_wb_addr);
        iss_zero     = is_zero(i_issue_rd);
        wr_en        = i_wb_valid && !wb_zero;
        // A write-back retiring the old producer this cycle lets the new producer issue.
        wb_frees_iss = wr_en && (i_wb_addr == i_issue_rd);
        issue_ready  = !busy_q[i_issue_rd] || wb_frees_iss || iss_zero || i_flush;
        issue_accept = i_issue_valid && issue_ready && !i_flush;

        busy_d = busy_q;
        if (wr_en) begin
            busy_d[i_wb_addr] = 1'b0;
        end
        if (issue_accept && !iss_zero) begin
            busy_d[i_issue_rd] = 1'b1;
        end
        if (i_flush) begin
            busy_d = '0;
        end

        err_d = err_q;
        if (wr_en && !i_flush && !busy_q[i_wb_addr]) begin
            err_d = 1'b1;
        end

        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                regs_q[i_wb_addr] <= i_wb_data;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign o_issue_ready = issue_ready;
    assign o_busy_vec    = busy_q;
    assign o_pending_cnt = cnt_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: the driver pushes hand-computed expectations into a
// scoreboard queue, and a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    localparam int SEL_RD0   = 0;
    localparam int SEL_RD1   = 1;
    localparam int SEL_RBUSY = 2;
    localparam int SEL_READY = 3;
    localparam int SEL_BVEC  = 4;
    localparam int SEL_CNT   = 5;
    localparam int SEL_ERR   = 6;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic [NRD-1:0]      o_rd_busy;
    logic                i_issue_valid;
    logic [AW-1:0]       i_issue_rd;
    logic                o_issue_ready;
    logic                i_wb_valid;
    logic [AW-1:0]       i_wb_addr;
    logic [XLEN-1:0]     i_wb_data;
    logic                i_flush;
    logic [NREGS-1:0]    o_busy_vec;
    logic [AW:0]         o_pending_cnt;
    logic                o_err;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_busy(o_rd_busy),
        .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_issue_ready(o_issue_ready),
        .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .o_busy_vec(o_busy_vec), .o_pending_cnt(o_pending_cnt),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          sel;
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_RD0:   return o_rd_data[31:0];
            SEL_RD1:   return o_rd_data[63:32];
            SEL_RBUSY: return 32'(o_rd_busy);
            SEL_READY: return 32'(o_issue_ready);
            SEL_BVEC:  return o_busy_vec;
            SEL_CNT:   return 32'(o_pending_cnt);
            SEL_ERR:   return 32'(o_err);
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    always @(negedge i_clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.sel);
            n_vec++;
            if (a !== e.val) begin
                n_miss++;
                $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, a, e.val, $time);
            end
        end
    end

    task automatic expect_v(input int sel, input string name, input logic [31:0] val);
        exp_t e;
        e.sel  = sel;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_issue_valid = 1'b0;
        i_issue_rd    = '0;
        i_wb_valid    = 1'b0;
        i_wb_addr     = '0;
        i_wb_data     = '0;
        i_flush       = 1'b0;
    endtask

    task automatic rdaddr(input int a0, input int a1);
        i_rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic issue(input int rd);
        i_issue_valid = 1'b1;
        i_issue_rd    = AW'(rd);
    endtask

    task automatic wb(input int addr, input logic [31:0] data);
        i_wb_valid = 1'b1;
        i_wb_addr  = AW'(addr);
        i_wb_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rdaddr(0, 0);
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;

        // Reset state and every register on both ports
        expect_v(SEL_BVEC, "reset_busy_vec", 32'h0);
        expect_v(SEL_CNT,  "reset_pending_cnt", 32'd0);
        expect_v(SEL_ERR,  "reset_err", 32'd0);
        for (int a = 0; a < NREGS; a++) begin
            rdaddr(a, NREGS - 1 - a);
            expect_v(SEL_RD0,   "reset_rd0", 32'h0);
            expect_v(SEL_RD1,   "reset_rd1", 32'h0);
            expect_v(SEL_RBUSY, "reset_rd_busy", 32'h0);
            step();
        end

        // Issue r5, then write-back with bypass
        idle(); issue(5); rdaddr(5, 0);
        expect_v(SEL_READY, "issue5_ready", 32'd1);
        step();
        idle(); rdaddr(5, 0);
        expect_v(SEL_RBUSY, "r5_rd_busy", 32'h1);
        expect_v(SEL_BVEC,  "r5_busy_vec", 32'h0000_0020);
        expect_v(SEL_CNT,   "r5_cnt", 32'd1);
        step();
        idle(); wb(5, 32'hDEAD_BEEF); rdaddr(5, 0);
        expect_v(SEL_RD0,   "r5_bypass_data", 32'hDEAD_BEEF);
        expect_v(SEL_RBUSY, "r5_bypass_busy", 32'h0);
        step();
        idle(); rdaddr(5, 0);
        expect_v(SEL_BVEC, "r5_cleared_vec", 32'h0);
        expect_v(SEL_CNT,  "r5_cleared_cnt", 32'd0);
        expect_v(SEL_RD0,  "r5_stored", 32'hDEAD_BEEF);
        expect_v(SEL_ERR,  "r5_err", 32'd0);
        step();

        // WAW hazard on r7, then same-cycle wb + issue
        idle(); issue(7);
        expect_v(SEL_READY, "issue7_first_ready", 32'd1);
        step();
        idle(); issue(7); rdaddr(7, 5);
        expect_v(SEL_READY, "issue7_waw_ready", 32'd0);
        expect_v(SEL_BVEC,  "issue7_waw_vec", 32'h0000_0080);
        expect_v(SEL_RD1,   "r5_port1", 32'hDEAD_BEEF);
        step();
        idle();
        expect_v(SEL_BVEC, "issue7_vec_unchanged", 32'h0000_0080);
        expect_v(SEL_CNT,  "issue7_cnt_unchanged", 32'd1);
        step();
        idle(); issue(7); wb(7, 32'hA5A5_0007); rdaddr(7, 0);
        expect_v(SEL_READY, "wb_issue7_ready", 32'd1);
        expect_v(SEL_RD0,   "wb_issue7_bypass", 32'hA5A5_0007);
        expect_v(SEL_RBUSY, "wb_issue7_rd_busy", 32'h0);
        step();
        idle(); rdaddr(7, 0);
        expect_v(SEL_BVEC,  "wb_issue7_vec", 32'h0000_0080);
        expect_v(SEL_CNT,   "wb_issue7_cnt", 32'd1);
        expect_v(SEL_RD0,   "wb_issue7_data", 32'hA5A5_0007);
        expect_v(SEL_RBUSY, "wb_issue7_still_busy", 32'h1);
        expect_v(SEL_ERR,   "wb_issue7_err", 32'd0);
        step();
        idle(); wb(7, 32'h0000_0077);
        step();

        // Zero register: issue and write-back are both inert
        idle(); issue(0); wb(0, 32'h0000_1234); rdaddr(0, 0);
        expect_v(SEL_READY, "zero_ready", 32'd1);
        expect_v(SEL_RD0,   "zero_bypass_blocked", 32'h0);
        expect_v(SEL_RBUSY, "zero_rd_busy", 32'h0);
        step();
        idle(); rdaddr(0, 7);
        expect_v(SEL_BVEC, "zero_vec", 32'h0);
        expect_v(SEL_RD0,  "zero_reads_zero", 32'h0);
        expect_v(SEL_RD1,  "r7_final", 32'h0000_0077);
        expect_v(SEL_ERR,  "zero_err", 32'd0);
        step();

        // Flush with a same-cycle write-back, then an unexpected write-back
        idle(); issue(1); step();
        idle(); issue(2); step();
        idle(); issue(3); step();
        idle(); issue(9); i_flush = 1'b1; wb(2, 32'h0000_0055);
        expect_v(SEL_CNT,   "preflush_cnt", 32'd3);
        expect_v(SEL_BVEC,  "preflush_vec", 32'h0000_000E);
        expect_v(SEL_READY, "flush_ready", 32'd1);
        step();
        idle(); rdaddr(2, 9);
        expect_v(SEL_BVEC, "flush_vec", 32'h0);
        expect_v(SEL_CNT,  "flush_cnt", 32'd0);
        expect_v(SEL_RD0,  "flush_wb_data", 32'h0000_0055);
        expect_v(SEL_ERR,  "flush_err", 32'd0);
        step();
        idle(); wb(4, 32'h0000_0044); rdaddr(0, 4);
        expect_v(SEL_RD1, "stray_wb_bypass", 32'h0000_0044);
        expect_v(SEL_ERR, "stray_wb_err_before", 32'd0);
        step();
        idle(); rdaddr(0, 4);
        expect_v(SEL_ERR, "stray_wb_err_set", 32'd1);
        expect_v(SEL_RD1, "stray_wb_data", 32'h0000_0044);
        step();
        idle();
        step();
        expect_v(SEL_ERR, "err_sticky", 32'd1);
        step();

        // Reset mid-operation with busy registers and an active write-back
        for (int r = 10; r < 14; r++) begin
            idle(); issue(r);
            expect_v(SEL_READY, "pre_rst_issue_ready", 32'd1);
            step();
        end
        idle(); i_rst = 1'b1; wb(10, 32'h0000_FFFF);
        expect_v(SEL_CNT,  "pre_rst_cnt", 32'd4);
        expect_v(SEL_BVEC, "pre_rst_vec", 32'h0000_3C00);
        expect_v(SEL_ERR,  "pre_rst_err", 32'd1);
        step();
        i_rst = 1'b0; idle(); rdaddr(10, 5);
        expect_v(SEL_BVEC, "post_rst_vec", 32'h0);
        expect_v(SEL_CNT,  "post_rst_cnt", 32'd0);
        expect_v(SEL_ERR,  "post_rst_err", 32'd0);
        expect_v(SEL_RD0,  "post_rst_wb_dropped", 32'h0);
        expect_v(SEL_RD1,  "post_rst_r5", 32'h0);
        step();

        step();
        step();
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
